// File: rtl/instruction_decode_if.sv
// ID-stage bus: IF/WB/hazard inputs plus the IF-loop controls and ID/EX register outputs.
// The debug read port exists only when MIPS_DEBUG_REGFILE_EN is defined.
interface instruction_decode_if #(
  parameter int NB_REG      = 32,
  parameter int NB_INSTR    = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CTRL     = 16
);
  logic                      i_valid;
  logic [NB_INSTR-1:0]       i_instr;
  logic [NB_REG-1:0]         i_pc;
  logic                      i_wb_we;
  logic [NB_REG_ADDR-1:0]    i_wb_addr;
  logic [NB_REG-1:0]         i_wb_data;
  logic [NB_REG_ADDR+1:0]    i_ex_dst;
  logic [NB_REG_ADDR+1:0]    i_mem_dst;
  logic                      o_hazard;
  logic                      o_branch;
  logic                      o_jump_rs;
  logic                      o_jump_inm;
  logic [NB_REG-1:0]         o_rs;
  logic [15:0]               o_inm_i;
  logic [25:0]               o_inm_j;
  logic [NB_REG-1:0]         o_pc;
  logic [NB_REG-1:0]         o_rs_data;
  logic [NB_REG-1:0]         o_rt_data;
  logic [NB_REG-1:0]         o_imm_ext;
  logic [2*NB_REG_ADDR-1:0]  o_src_addr;
  logic [NB_REG_ADDR-1:0]    o_rd_addr;
  logic [NB_CTRL-1:0]        o_ctrl;
`ifdef MIPS_DEBUG_REGFILE_EN
  logic [NB_REG_ADDR-1:0]    i_debug_reg_addr;
  logic [NB_REG-1:0]         o_debug_reg_data;
`endif

  modport slave (
    input  i_valid, i_instr, i_pc, i_wb_we, i_wb_addr, i_wb_data, i_ex_dst, i_mem_dst,
    output o_hazard, o_branch, o_jump_rs, o_jump_inm, o_rs, o_inm_i, o_inm_j,
    output o_pc, o_rs_data, o_rt_data, o_imm_ext, o_src_addr, o_rd_addr, o_ctrl
`ifdef MIPS_DEBUG_REGFILE_EN
    , input i_debug_reg_addr, output o_debug_reg_data
`endif
  );

  modport master (
    output i_valid, i_instr, i_pc, i_wb_we, i_wb_addr, i_wb_data, i_ex_dst, i_mem_dst,
    input  o_hazard, o_branch, o_jump_rs, o_jump_inm, o_rs, o_inm_i, o_inm_j,
    input  o_pc, o_rs_data, o_rt_data, o_imm_ext, o_src_addr, o_rd_addr, o_ctrl
`ifdef MIPS_DEBUG_REGFILE_EN
    , output i_debug_reg_addr, input o_debug_reg_data
`endif
  );
endinterface

// File: rtl/instruction_decode.sv
// MIPS ID stage: regfile, control decode, branch/jump resolution, hazard detect, ID/EX register.
// Define MIPS_DEBUG_REGFILE_EN to add a combinational regfile debug read port.
module instruction_decode #(
  parameter int NB_REG      = 32,
  parameter int NB_INSTR    = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CTRL     = 16
) (
  input logic                  i_clock,
  input logic                  i_reset,
  instruction_decode_if.slave  bus
);
  localparam int NA = NB_REG_ADDR;

  logic [NB_REG-1:0] regs [2**NA];

  logic [5:0]    opcode, funct;
  logic [NA-1:0] rs, rt, rd;
  logic [15:0]   imm16;
  assign opcode = bus.i_instr[NB_INSTR-1 -: 6];
  assign rs     = bus.i_instr[25:21];
  assign rt     = bus.i_instr[20:16];
  assign rd     = bus.i_instr[15:11];
  assign funct  = bus.i_instr[5:0];
  assign imm16  = bus.i_instr[15:0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 2**NA; i++) regs[i] <= '0;
    end else if (bus.i_valid && bus.i_wb_we && bus.i_wb_addr != '0) begin
      regs[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end

  // Write-first bypass so a WB in the same cycle is seen by this decode
  logic [NB_REG-1:0] rs_val, rt_val;
  assign rs_val = (rs == '0) ? '0 :
                  (bus.i_wb_we && bus.i_wb_addr == rs) ? bus.i_wb_data : regs[rs];
  assign rt_val = (rt == '0) ? '0 :
                  (bus.i_wb_we && bus.i_wb_addr == rt) ? bus.i_wb_data : regs[rt];

  logic is_r, is_jr, is_jalr, is_j, is_jal, is_beq, is_bne, is_imm, is_load, is_store;
  assign is_r     = opcode == 6'h00;
  assign is_jr    = is_r && funct == 6'h08;
  assign is_jalr  = is_r && funct == 6'h09;
  assign is_j     = opcode == 6'h02;
  assign is_jal   = opcode == 6'h03;
  assign is_beq   = opcode == 6'h04;
  assign is_bne   = opcode == 6'h05;
  assign is_imm   = opcode[5:3] == 3'b001;
  assign is_load  = opcode[5:3] == 3'b100 && opcode[2:0] <= 3'd5;
  assign is_store = opcode == 6'h28 || opcode == 6'h29 || opcode == 6'h2B;

  logic [NB_CTRL-1:0] ctrl;
  logic [NA-1:0]      rd_addr;
  logic [NB_REG-1:0]  imm_ext;

  always_comb begin
    ctrl        = '0;
    ctrl[5:0]   = is_r ? funct : opcode;
    ctrl[6]     = is_imm || is_load || is_store;
    ctrl[7]     = is_jal || is_jalr;
    ctrl[8]     = is_load;
    ctrl[9]     = is_store;
    ctrl[11:10] = (is_load || is_store) ? opcode[1:0] : 2'b00;
    ctrl[12]    = is_load && opcode[2];
    ctrl[13]    = (is_r && !is_jr) || is_load || is_imm || is_jal;
    ctrl[14]    = is_load;
    ctrl[15]    = is_r;

    rd_addr = is_r ? rd : (is_jal ? '1 : rt);

    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_ext = NB_REG'(imm16);
      6'h0F:               imm_ext = NB_REG'(imm16) << 16;
      default:             imm_ext = {{(NB_REG-16){imm16[15]}}, imm16};
    endcase
  end

  // Hazard detection; register 0 never creates a dependency
  logic          ex_rw, ex_mr, mem_mr;
  logic [NA-1:0] ex_rd, mem_rd;
  assign ex_rw  = bus.i_ex_dst[NA+1];
  assign ex_mr  = bus.i_ex_dst[NA];
  assign ex_rd  = bus.i_ex_dst[NA-1:0];
  assign mem_mr = bus.i_mem_dst[NA];
  assign mem_rd = bus.i_mem_dst[NA-1:0];

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, is_br, rt_src, load_use, ctl_hz, hazard;
  assign ex_hit_rs  = ex_rd != '0 && ex_rd == rs;
  assign ex_hit_rt  = ex_rd != '0 && ex_rd == rt;
  assign mem_hit_rs = mem_rd != '0 && mem_rd == rs;
  assign mem_hit_rt = mem_rd != '0 && mem_rd == rt;
  assign is_br      = is_beq || is_bne;
  assign rt_src     = is_r || is_br || is_store;
  assign load_use   = ex_mr && (ex_hit_rs || (rt_src && ex_hit_rt));
  // Branch/JR compare in ID, so any pending producer in EX or load in MEM must resolve first
  assign ctl_hz     = (is_br || is_jr || is_jalr) &&
                      ((ex_rw && (ex_hit_rs || (is_br && ex_hit_rt))) ||
                       (mem_mr && (mem_hit_rs || (is_br && mem_hit_rt))));
  assign hazard     = load_use || ctl_hz;

  assign bus.o_hazard   = hazard;
  assign bus.o_branch   = !hazard && ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val));
  assign bus.o_jump_rs  = !hazard && (is_jr || is_jalr);
  assign bus.o_jump_inm = !hazard && (is_j || is_jal);
  assign bus.o_rs       = rs_val;
  assign bus.o_inm_i    = imm16;
  assign bus.o_inm_j    = bus.i_instr[25:0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bus.o_pc       <= '0;
      bus.o_rs_data  <= '0;
      bus.o_rt_data  <= '0;
      bus.o_imm_ext  <= '0;
      bus.o_src_addr <= '0;
      bus.o_rd_addr  <= '0;
      bus.o_ctrl     <= '0;
    end else if (bus.i_valid) begin
      if (hazard) begin
        bus.o_pc       <= '0;
        bus.o_rs_data  <= '0;
        bus.o_rt_data  <= '0;
        bus.o_imm_ext  <= '0;
        bus.o_src_addr <= '0;
        bus.o_rd_addr  <= '0;
        bus.o_ctrl     <= '0;
      end else begin
        bus.o_pc       <= bus.i_pc;
        bus.o_rs_data  <= rs_val;
        bus.o_rt_data  <= rt_val;
        bus.o_imm_ext  <= imm_ext;
        bus.o_src_addr <= {rs, rt};
        bus.o_rd_addr  <= rd_addr;
        bus.o_ctrl     <= ctrl;
      end
    end
  end

`ifdef MIPS_DEBUG_REGFILE_EN
  assign bus.o_debug_reg_data = (bus.i_debug_reg_addr == '0) ? '0 : regs[bus.i_debug_reg_addr];
`endif
endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: vector table plus hand sequences for reset,
// writeback bypass, step-enable hold and the debug port.
module tb_instruction_decode;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instruction_decode_if bus ();
  instruction_decode dut (.i_clock(clock), .i_reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [9:0]  src;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } idex_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  ex_dst, mem_dst;
    logic        haz, br, jrs, jinm;
    logic [31:0] rs_data, rt_data, imm;
    logic [9:0]  src;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } vec_t;

  idex_t sb[$];
  vec_t  vecs[$];
  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_idex(input string tag);
    idex_t e;
    if (sb.size() == 0) begin
      ntests++; nfail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " pc"},      bus.o_pc,       e.pc);
    chk({tag, " rs_data"}, bus.o_rs_data,  e.rs_data);
    chk({tag, " rt_data"}, bus.o_rt_data,  e.rt_data);
    chk({tag, " imm_ext"}, bus.o_imm_ext,  e.imm);
    chk({tag, " src"},     32'(bus.o_src_addr), 32'(e.src));
    chk({tag, " rd"},      32'(bus.o_rd_addr),  32'(e.rd));
    chk({tag, " ctrl"},    32'(bus.o_ctrl),     32'(e.ctrl));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] jtype(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  function automatic vec_t mk(logic [31:0] instr, logic [6:0] ex, logic [6:0] mem,
                              logic haz, logic br, logic jrs, logic jinm,
                              logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                              logic [9:0] src, logic [4:0] rd, logic [15:0] ctrl);
    return '{instr, ex, mem, haz, br, jrs, jinm, rsd, rtd, imm, src, rd, ctrl};
  endfunction

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bus.i_instr   = 32'h0;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = a;
    bus.i_wb_data = d;
    step();
    bus.i_wb_we   = 1'b0;
  endtask

  initial begin
    vec_t  v;
    idex_t e;
    bus.i_valid = 1'b1; bus.i_instr = '0; bus.i_pc = '0;
    bus.i_wb_we = 1'b0; bus.i_wb_addr = '0; bus.i_wb_data = '0;
    bus.i_ex_dst = '0; bus.i_mem_dst = '0;
`ifdef MIPS_DEBUG_REGFILE_EN
    bus.i_debug_reg_addr = '0;
`endif

    #1;
    chk("reset ctrl", 32'(bus.o_ctrl), 32'h0);
    chk("reset pc",   bus.o_pc,        32'h0);
    #11 reset = 1'b0;
    step();

    wb_write(5'd1,  32'h5);
    wb_write(5'd2,  32'h5);
    wb_write(5'd8,  32'h88);
    wb_write(5'd31, 32'h0040_0100);

    vecs.push_back(mk(rtype(8,1,9,'h20),    0,     0,     0,0,0,0, 'h88, 5, 'h4820, 'h101, 9, 'hA020));
    vecs.push_back(mk(rtype(8,1,9,'h20),    'h68,  0,     1,0,0,0, 'h88, 5, 0, 0, 0, 0));
    vecs.push_back(mk(itype(4,1,2,'h10),    0,     0,     0,1,0,0, 5, 5, 'h10, 'h22, 2, 'h0004));
    vecs.push_back(mk(itype(5,1,2,'h10),    0,     0,     0,0,0,0, 5, 5, 'h10, 'h22, 2, 'h0005));
    vecs.push_back(mk(itype(4,1,2,'h10),    0,     'h22,  1,0,0,0, 5, 5, 0, 0, 0, 0));
    vecs.push_back(mk(rtype(31,0,0,8),      'h5F,  0,     1,0,0,0, 'h0040_0100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(rtype(31,0,0,8),      0,     0,     0,0,1,0, 'h0040_0100, 0, 'h8, 'h3E0, 0, 'h8008));
    vecs.push_back(mk(rtype(31,0,31,9),     0,     0,     0,0,1,0, 'h0040_0100, 0, 'hFFFF_F809, 'h3E0, 31, 'hA089));
    vecs.push_back(mk(itype('hD,1,10,'h8000), 0,   0,     0,0,0,0, 5, 0, 'h0000_8000, 'h2A, 10, 'h204D));
    vecs.push_back(mk(itype(8,1,10,'h8000), 0,     0,     0,0,0,0, 5, 0, 'hFFFF_8000, 'h2A, 10, 'h2048));
    vecs.push_back(mk(itype('hF,0,11,'h1234), 0,   0,     0,0,0,0, 0, 0, 'h1234_0000, 'h0B, 11, 'h204F));
    vecs.push_back(mk(jtype(3,'h123),       0,     0,     0,0,0,1, 0, 0, 'h123, 0, 31, 'h2083));
    vecs.push_back(mk(jtype(2,'h3FFFFFF),   0,     0,     0,0,0,1, 'h0040_0100, 'h0040_0100, 'hFFFF_FFFF, 'h3FF, 31, 'h0002));
    vecs.push_back(mk(itype('h23,1,12,4),   0,     0,     0,0,0,0, 5, 0, 4, 'h2C, 12, 'h6D63));
    vecs.push_back(mk(itype('h24,2,12,'hFFFF), 0,  0,     0,0,0,0, 5, 0, 'hFFFF_FFFF, 'h4C, 12, 'h7164));
    vecs.push_back(mk(itype('h29,1,2,2),    0,     0,     0,0,0,0, 5, 5, 2, 'h22, 2, 'h0669));
    vecs.push_back(mk(itype('h2B,1,8,0),    'h68,  0,     1,0,0,0, 5, 'h88, 0, 0, 0, 0));
    vecs.push_back(mk(itype(8,8,13,1),      'h6D,  0,     0,0,0,0, 'h88, 0, 1, 'h10D, 13, 'h2048));
    vecs.push_back(mk(rtype(0,0,9,'h20),    'h60,  0,     0,0,0,0, 0, 0, 'h4820, 0, 9, 'hA020));
    vecs.push_back(mk(itype(4,1,2,'h10),    'h41,  0,     1,0,0,0, 5, 5, 0, 0, 0, 0));
    vecs.push_back(mk(itype(4,1,2,'h10),    0,     'h41,  0,1,0,0, 5, 5, 'h10, 'h22, 2, 'h0004));
    vecs.push_back(mk(rtype(8,1,9,'h20),    0,     'h68,  0,0,0,0, 'h88, 5, 'h4820, 'h101, 9, 'hA020));

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] pc;
      string tag;
      v   = vecs[i];
      pc  = 32'h1000 + 32'(i) * 4;
      tag = $sformatf("v%0d", i);
      bus.i_instr = v.instr; bus.i_pc = pc;
      bus.i_ex_dst = v.ex_dst; bus.i_mem_dst = v.mem_dst;
      #1;
      chk({tag, " hazard"},   32'(bus.o_hazard),   32'(v.haz));
      chk({tag, " branch"},   32'(bus.o_branch),   32'(v.br));
      chk({tag, " jump_rs"},  32'(bus.o_jump_rs),  32'(v.jrs));
      chk({tag, " jump_inm"}, 32'(bus.o_jump_inm), 32'(v.jinm));
      chk({tag, " rs"},       bus.o_rs,            v.rs_data);
      chk({tag, " inm_i"},    32'(bus.o_inm_i),    32'(v.instr[15:0]));
      chk({tag, " inm_j"},    32'(bus.o_inm_j),    32'(v.instr[25:0]));
      if (v.haz) e = '0;
      else e = '{pc, v.rs_data, v.rt_data, v.imm, v.src, v.rd, v.ctrl};
      sb.push_back(e);
      step();
      check_idex(tag);
    end
    bus.i_ex_dst = '0; bus.i_mem_dst = '0;

`ifdef MIPS_DEBUG_REGFILE_EN
    bus.i_debug_reg_addr = 5'd31;
    #1 chk("dbg r31", bus.o_debug_reg_data, 32'h0040_0100);
    bus.i_debug_reg_addr = 5'd0;
    #1 chk("dbg r0", bus.o_debug_reg_data, 32'h0);
`endif

    // Writeback bypass into a decode in the same cycle
    bus.i_instr = rtype(3,0,4,'h21); bus.i_pc = 32'h2000;
    bus.i_wb_we = 1'b1; bus.i_wb_addr = 5'd3; bus.i_wb_data = 32'hDEAD_BEEF;
    #1 chk("bypass rs", bus.o_rs, 32'hDEAD_BEEF);
    sb.push_back('{32'h2000, 32'hDEAD_BEEF, 32'h0, 32'h2021, 10'h60, 5'd4, 16'hA021});
    step();
    check_idex("bypass");
    bus.i_wb_we = 1'b0;
    #1 chk("r3 stored", bus.o_rs, 32'hDEAD_BEEF);
    bus.i_instr = rtype(0,0,4,'h21);
    bus.i_wb_we = 1'b1; bus.i_wb_addr = 5'd0; bus.i_wb_data = 32'h5;
    #1 chk("r0 bypass", bus.o_rs, 32'h0);
    step();
    bus.i_wb_we = 1'b0;
    #1 chk("r0 stays 0", bus.o_rs, 32'h0);

    // r2 becomes 6 via bypass: BEQ not taken, BNE taken
    bus.i_instr = itype(4,1,2,'h10);
    bus.i_wb_we = 1'b1; bus.i_wb_addr = 5'd2; bus.i_wb_data = 32'h6;
    #1 chk("beq ne bypass", 32'(bus.o_branch), 32'h0);
    step();
    bus.i_wb_we = 1'b0;
    bus.i_instr = itype(5,1,2,'h10);
    #1 chk("bne ne", 32'(bus.o_branch), 32'h1);
    step();
    bus.i_instr = itype(4,1,2,'h10);
    #1 chk("beq ne", 32'(bus.o_branch), 32'h0);
    step();

    // Step enable low: ID/EX and regfile hold
    bus.i_valid = 1'b0;
    bus.i_instr = itype('hF,0,11,'h1234);
    bus.i_wb_we = 1'b1; bus.i_wb_addr = 5'd11; bus.i_wb_data = 32'h77;
    step();
    chk("hold ctrl", 32'(bus.o_ctrl), 32'h0004);
    bus.i_valid = 1'b1; bus.i_wb_we = 1'b0;
    bus.i_instr = rtype(11,0,4,'h21);
    #1 chk("hold no write", bus.o_rs, 32'h0);

    // Asynchronous reset mid-cycle
    bus.i_instr = rtype(8,1,9,'h20);
    step();
    chk("pre-reset ctrl", 32'(bus.o_ctrl), 32'hA020);
    #2 reset = 1'b1;
    #1;
    chk("async rst ctrl", 32'(bus.o_ctrl), 32'h0);
    chk("async rst rd",   32'(bus.o_rd_addr), 32'h0);
    chk("async rst rs_data", bus.o_rs_data, 32'h0);
    chk("async rst pc",   bus.o_pc, 32'h0);
    #1 reset = 1'b0;
    bus.i_instr = rtype(5,0,1,'h21); bus.i_pc = 32'h3000;
    sb.push_back('{32'h3000, 32'h0, 32'h0, 32'h0821, 10'hA0, 5'd1, 16'hA021});
    step();
    check_idex("post-reset");
    bus.i_instr = rtype(1,0,4,'h21);
    #1 chk("r1 cleared", bus.o_rs, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
